// File: rtl/led_pattern_sched.sv
// Round-robin scheduler that shares one board LED among N_REQ requesters.
// A granted requester's pattern is latched and played MSB-first, one bit per
// DIV clocks. An optional LED-off gap follows, then the block re-arbitrates
// starting from the requester after the last owner.
module led_pattern_sched #(
    parameter int CLK_HZ    = 24000000,
    parameter int TICK_HZ   = 8,
    parameter int N_REQ     = 4,
    parameter int PAT_W     = 16,
    parameter int GAP_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*PAT_W-1:0] pat,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   led_out,
    output logic [1:0]             state_dbg
);

    // Request/grant handshake: req[i] is a level that acts as "valid". The
    // one-cycle grant[i] pulse acts as "ready" and marks the cycle in which
    // pat[i] was captured. After the grant, both req[i] and pat[i] are ignored
    // until the matching done[i] pulse. A requester that wants another turn
    // keeps req[i] high and is re-arbitrated with the lowest priority.

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int BIT_W = $clog2(PAT_W + 1);
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int PTR_W = $clog2(N_REQ);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(PAT_W);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]       state;
    logic [PRE_W-1:0] presc;
    logic             tick;
    logic [BIT_W-1:0] bit_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [PAT_W-1:0] shreg;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner_next;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] scan_idx;
    logic             any_req;
    logic [PAT_W-1:0] pat_arr [N_REQ];

    assign tick       = (presc == PRE_LAST);
    assign busy       = (state == S_PLAY) || (state == S_GAP);
    assign state_dbg  = state;
    assign owner_next = (owner == PTR_LAST) ? '0 : owner + 1'b1;

    // Split the flat pattern bus into one word per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pat_arr[i] = pat[i*PAT_W +: PAT_W];
        end
    end

    // Pick the first asserted request at or after rr_ptr. The scan runs from
    // the farthest offset down so the closest hit is the one that sticks.
    always_comb begin
        any_req  = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[scan_idx]) begin
                any_req = 1'b1;
                pick    = scan_idx;
            end
        end
    end

    // Bit-rate prescaler: free-runs in PLAY/GAP and holds at zero in IDLE,
    // so every pattern starts with a full-length first bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (state == S_IDLE || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Scheduler FSM: arbitrate, shift the latched pattern out, then hold the
    // LED dark for the gap before handing over.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            led_out <= 1'b0;
            grant   <= '0;
            done    <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            owner   <= '0;
            rr_ptr  <= '0;
        end else begin
            grant <= '0;
            done  <= '0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant   <= ONE_HOT0 << pick;
                        shreg   <= pat_arr[pick];
                        led_out <= pat_arr[pick][PAT_W-1];
                        bit_idx <= BIT_W'(1);
                        owner   <= pick;
                        state   <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        if (bit_idx != BIT_END) begin
                            // shreg[PAT_W-2] always holds the next bit to show.
                            led_out <= shreg[PAT_W-2];
                            shreg   <= {shreg[PAT_W-2:0], 1'b0};
                            bit_idx <= bit_idx + 1'b1;
                        end else begin
                            led_out <= 1'b0;
                            gap_cnt <= '0;
                            if (GAP_TICKS == 0) begin
                                done   <= ONE_HOT0 << owner;
                                rr_ptr <= owner_next;
                                state  <= S_IDLE;
                            end else begin
                                state <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    led_out <= 1'b0;
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            done   <= ONE_HOT0 << owner;
                            rr_ptr <= owner_next;
                            state  <= S_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    led_out <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed bench for led_pattern_sched with DIV=4, N_REQ=4, PAT_W=4.
// dut uses GAP_TICKS=2; dut_ng uses GAP_TICKS=0. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_led_pattern_sched;

    localparam int N_REQ = 4;
    localparam int PAT_W = 4;

    logic                   clk;
    logic                   reset_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*PAT_W-1:0] pat;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   led_out;
    logic [1:0]             state_dbg;

    logic [N_REQ-1:0]       req_b;
    logic [N_REQ*PAT_W-1:0] pat_b;
    logic [N_REQ-1:0]       grant_b;
    logic [N_REQ-1:0]       done_b;
    logic                   busy_b;
    logic                   led_b;
    logic [1:0]             state_dbg_b;

    logic [N_REQ-1:0] exp_q[$];
    logic [N_REQ-1:0] exp_done_q[$];

    int checks;
    int errors;
    int cyc;

    led_pattern_sched #(
        .CLK_HZ(16), .TICK_HZ(4), .N_REQ(N_REQ), .PAT_W(PAT_W), .GAP_TICKS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .pat(pat),
        .grant(grant), .done(done), .busy(busy), .led_out(led_out),
        .state_dbg(state_dbg)
    );

    led_pattern_sched #(
        .CLK_HZ(16), .TICK_HZ(4), .N_REQ(N_REQ), .PAT_W(PAT_W), .GAP_TICKS(0)
    ) dut_ng (
        .clk(clk), .reset_n(reset_n), .req(req_b), .pat(pat_b),
        .grant(grant_b), .done(done_b), .busy(busy_b), .led_out(led_b),
        .state_dbg(state_dbg_b)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Wait (bounded) for a grant pulse and compare it with the queue head.
    task automatic wait_grant(input string tag, output int lat, output int at_cyc);
        logic [N_REQ-1:0] e;
        lat = 0;
        @(negedge clk);
        while (grant == '0 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        at_cyc = cyc;
        e = (exp_q.size() == 0) ? '0 : exp_q.pop_front();
        chk(tag, grant, e);
    endtask

    // Wait (bounded) for a done pulse and compare it with the queue head.
    task automatic wait_done(input string tag);
        logic [N_REQ-1:0] e;
        int n;
        n = 0;
        @(negedge clk);
        while (done == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        e = (exp_done_q.size() == 0) ? '0 : exp_done_q.pop_front();
        chk(tag, done, e);
    endtask

    // Called on the first cycle grant is visible: checks each LED bit held
    // 4 clocks, 8 dark gap clocks, and done 24 clocks after the grant.
    task automatic play_check(input string tag, input logic [PAT_W-1:0] p,
                              input logic [N_REQ-1:0] who);
        logic e_led;
        for (int k = 0; k < 24; k++) begin
            e_led = (k < 16) ? p[PAT_W-1-(k/4)] : 1'b0;
            chk({tag, "_led"}, led_out, e_led);
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_nodone"}, done, '0);
            @(negedge clk);
        end
        chk({tag, "_done"}, done, who);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_ledoff"}, led_out, 1'b0);
    endtask

    initial begin
        int lat;
        int g_at;
        int prev_at;
        logic [N_REQ-1:0] seq [5];

        checks  = 0;
        errors  = 0;
        cyc     = 0;
        reset_n = 1'b0;
        req     = '0;
        pat     = '0;
        req_b   = '0;
        pat_b   = '0;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_led", led_out, 1'b0);
        chk("rst_grant", grant, '0);
        chk("rst_done", done, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", state_dbg, 2'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single requester, pattern 1010
        pat[3:0] = 4'b1010;
        req      = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_grant("t1_grant", lat, g_at);
        chk("t1_lat", lat, 0);
        req = '0;
        play_check("t1", 4'b1010, 4'b0001);

        // All four requesting from a fresh rr_ptr: strict rotation, 25 clk apart
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        pat = {4'b0011, 4'b1001, 4'b0110, 4'b1101};
        for (int i = 0; i < 5; i++) exp_q.push_back(seq[i]);
        req = 4'b1111;
        prev_at = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant("t2_grant", lat, g_at);
            if (i == 0) chk("t2_lat", lat, 0);
            else        chk("t2_spacing", g_at - prev_at, 25);
            prev_at = g_at;
        end

        // Owner 0 playing; only 1 requests -> 1 next, then rr_ptr=2 wraps to 0
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        wait_grant("t3_grant1", lat, g_at);
        chk("t3_spacing1", g_at - prev_at, 25);
        prev_at = g_at;
        req = 4'b0011;
        exp_q.push_back(4'b0001);
        wait_grant("t3_wrap", lat, g_at);
        chk("t3_spacing2", g_at - prev_at, 25);
        req = '0;
        exp_done_q.push_back(4'b0001);
        wait_done("t3_done");

        // One-cycle request, pattern changed after grant
        pat[3:0] = 4'b1101;
        req      = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_grant("t4_grant", lat, g_at);
        chk("t4_lat", lat, 0);
        req      = '0;
        pat[3:0] = 4'b0000;
        play_check("t4", 4'b1101, 4'b0001);

        // Reset in the middle of bit 2
        pat[3:0] = 4'b1111;
        req      = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_grant("t5_grant", lat, g_at);
        req = '0;
        repeat (8) @(negedge clk);
        chk("t5_led_before", led_out, 1'b1);
        chk("t5_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t5_led_rst", led_out, 1'b0);
        chk("t5_busy_rst", busy, 1'b0);
        chk("t5_done_rst", done, '0);
        chk("t5_state_rst", state_dbg, 2'd0);
        @(negedge clk);
        chk("t5_done_hold", done, '0);
        reset_n = 1'b1;
        req     = 4'b0010;
        exp_q.push_back(4'b0010);
        wait_grant("t5_regrant", lat, g_at);
        chk("t5_lat", lat, 0);
        req = '0;
        play_check("t5", 4'b0110, 4'b0010);

        // No-gap build: 1111 lights 16 clocks, done on the 16th clock after grant
        pat_b[3:0] = 4'b1111;
        req_b      = 4'b0001;
        @(negedge clk);
        chk("t6_grant", grant_b, 4'b0001);
        req_b = '0;
        for (int k = 0; k < 16; k++) begin
            chk("t6_led", led_b, 1'b1);
            chk("t6_nodone", done_b, '0);
            @(negedge clk);
        end
        chk("t6_done", done_b, 4'b0001);
        chk("t6_ledoff", led_b, 1'b0);
        chk("t6_idle", busy_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
